// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared fetch-stage state encoding and PC constants
package fetch_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} fetch_state_t;
  localparam logic [31:0] BOOT_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'd3;
  endfunction
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: PC-tagged instruction FIFO between fetch and decode
module fetch_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  logic [31:0]             push_instr,
  input  logic [31:0]             push_pc,
  output logic [$clog2(DEPTH):0]  count,
  output logic [31:0]             head_instr,
  output logic [31:0]             head_pc
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_pc [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  // pointers and occupancy; a flush empties the buffer outright
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // storage carries no reset; the head is masked to zero while empty
  always_ff @(posedge clk)
    if (push && !flush) begin
      mem_instr[wr_ptr] <= push_instr;
      mem_pc[wr_ptr] <= push_pc;
    end
  assign head_instr = count != '0 ? mem_instr[rd_ptr] : '0;
  assign head_pc = count != '0 ? mem_pc[rd_ptr] : '0;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch FSM with redirect discard and PC-tagged buffer
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] BOOT_PC = BOOT_PC_DEFAULT,
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        halted
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  fetch_state_t state, state_nx;
  logic [31:0] fetch_pc, fetch_pc_nx, tag_pc;
  logic [CW-1:0] outstanding, outstanding_nx, discard_cnt, discard_nx, count;
  logic rsp, gnt, push, pop;
  // while no discards are pending the outstanding requests are the contiguous
  // words just below fetch_pc, so the oldest one's PC is recovered arithmetically
  always_comb begin
    rsp = imem_rvalid && outstanding != '0;
    imem_req = state == RUN && !halt && !redirect_valid && 32'(outstanding) + 32'(count) < BUF_DEPTH;
    gnt = imem_req && imem_gnt;
    instr_valid = count != '0 && !redirect_valid;
    pop = instr_valid && instr_ready;
    push = rsp && discard_cnt == '0 && !redirect_valid;
    tag_pc = fetch_pc - (32'(outstanding) << 2);
    outstanding_nx = outstanding + CW'(gnt) - CW'(rsp);
    discard_nx = redirect_valid ? outstanding - CW'(rsp) :
                 rsp && discard_cnt != '0 ? discard_cnt - CW'(1) : discard_cnt;
    fetch_pc_nx = redirect_valid ? word_align(redirect_pc) : gnt ? fetch_pc + PC_INC : fetch_pc;
    state_nx = state == IDLE ? RUN :
               state == HALTED ? (halt ? HALTED : RUN) :
               redirect_valid ? (discard_nx != '0 ? DRAIN : RUN) :
               state == DRAIN ? (discard_nx == '0 ? RUN : DRAIN) :
               halt && outstanding_nx == '0 ? HALTED : RUN;
    halted = state == HALTED;
    imem_addr = fetch_pc;
  end
  // fetch state, PC and request accounting; reset abandons in-flight requests
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      fetch_pc <= word_align(BOOT_PC);
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      state <= state_nx;
      fetch_pc <= fetch_pc_nx;
      outstanding <= outstanding_nx;
      discard_cnt <= discard_nx;
    end
  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk(clk),
    .reset(reset),
    .flush(redirect_valid),
    .push(push),
    .pop(pop),
    .push_instr(imem_rdata),
    .push_pc(tag_pc),
    .count(count),
    .head_instr(instr),
    .head_pc(instr_pc)
  );
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and random checks against a queue-based fetch model
module tb_fetch_sequencer;
  localparam int D = 2;
  localparam logic [31:0] BOOT = 32'h0000_0000;
  logic clk = 0, reset;
  logic imem_req, imem_gnt, imem_rvalid, redirect_valid, halt, instr_valid, instr_ready, halted;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
  int errors = 0, checks = 0;
  int mode, discard, grants;
  int unsigned p_gnt, p_rsp, p_rdy, p_spur;
  logic [31:0] pc, cap_pc, resume_pc;
  logic cap;
  logic [31:0] pend[$], fq_pc[$], memq[$];

  // free-running clock
  always #5 clk = ~clk;

  fetch_sequencer #(.BOOT_PC(BOOT), .BUF_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .halted(halted)
  );

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    imem_gnt = $urandom_range(0, 99) < p_gnt;
    instr_ready = $urandom_range(0, 99) < p_rdy;
    if (memq.size() != 0) begin
      imem_rvalid = $urandom_range(0, 99) < p_rsp;
      imem_rdata = hash(memq[0]);
    end else begin
      imem_rvalid = $urandom_range(0, 99) < p_spur;
      imem_rdata = $urandom;
    end
  endtask

  task automatic model_reset();
    mode = 0;
    pc = BOOT;
    discard = 0;
    pend.delete();
    fq_pc.delete();
    memq.delete();
  endtask

  task automatic step();
    logic er, ev, rsp;
    logic [31:0] t;
    #1;
    er = mode == 1 && !halt && !redirect_valid && pend.size() + fq_pc.size() < D;
    ev = fq_pc.size() != 0 && !redirect_valid;
    chk("imem_req", 32'(imem_req), 32'(er));
    chk("imem_addr", imem_addr, pc);
    chk("instr_valid", 32'(instr_valid), 32'(ev));
    chk("instr_pc", instr_pc, fq_pc.size() != 0 ? fq_pc[0] : 32'h0);
    chk("instr", instr, fq_pc.size() != 0 ? hash(fq_pc[0]) : 32'h0);
    chk("halted", 32'(halted), 32'(mode == 3));
    if (cap && instr_valid && instr_ready) begin
      cap_pc = instr_pc;
      cap = 0;
    end
    if (imem_req && imem_gnt) grants++;
    if (imem_rvalid && memq.size() != 0) void'(memq.pop_front());
    if (imem_req && imem_gnt) memq.push_back(imem_addr);
    rsp = imem_rvalid && pend.size() != 0;
    if (ev && instr_ready) void'(fq_pc.pop_front());
    if (rsp) begin
      t = pend.pop_front();
      if (!redirect_valid) begin
        if (discard == 0) fq_pc.push_back(t);
        else discard--;
      end
    end
    if (redirect_valid) begin
      fq_pc.delete();
      discard = pend.size();
      pc = redirect_pc & ~32'd3;
    end else if (er && imem_gnt) begin
      pend.push_back(pc);
      pc = pc + 32'd4;
    end
    case (mode)
      0: mode = 1;
      3: mode = halt ? 3 : 1;
      default: mode = redirect_valid ? (discard > 0 ? 2 : 1) :
                      mode == 2 ? (discard == 0 ? 1 : 2) :
                      (halt && pend.size() == 0) ? 3 : 1;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; redirect_valid = 0;
    redirect_pc = 0; halt = 0; instr_ready = 0;
    reset = 0;
    #1;
    model_reset();
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_imem_addr", imem_addr, BOOT);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    repeat (n) @(posedge clk);
    #1;
    reset = 1;
  endtask

  initial begin
    reset = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; redirect_valid = 0;
    redirect_pc = 0; halt = 0; instr_ready = 0;
    p_gnt = 0; p_rsp = 0; p_rdy = 0; p_spur = 0;
    cap = 0; cap_pc = 32'hDEAD_BEEF; grants = 0; resume_pc = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset(2);
    p_gnt = 100; p_rsp = 100; p_rdy = 100;
    repeat (20) begin drive(); step(); end
    p_rdy = 0;
    grants = 0;
    repeat (10) begin drive(); step(); end
    chk("stall_grants_le2", 32'(grants <= 2), 32'h1);
    chk("stall_no_req", 32'(imem_req), 32'h0);
    p_gnt = 0; p_rdy = 100;
    repeat (6) begin drive(); step(); end
    p_gnt = 100; p_rsp = 0;
    repeat (3) begin drive(); step(); end
    chk("two_outstanding", 32'(memq.size()), 32'd2);
    drive();
    redirect_valid = 1; redirect_pc = 32'h100;
    step();
    redirect_valid = 0;
    p_rsp = 100;
    cap = 1;
    repeat (20) begin drive(); step(); end
    chk("redirect_first_pc", cap_pc, 32'h100);
    drive();
    redirect_valid = 1; redirect_pc = 32'h203;
    step();
    redirect_valid = 0;
    chk("redirect_align", imem_addr, 32'h200);
    p_gnt = 0;
    repeat (6) begin drive(); step(); end
    p_gnt = 100; p_rsp = 0;
    drive(); step();
    resume_pc = pc;
    halt = 1; p_gnt = 0;
    repeat (2) begin drive(); step(); end
    chk("halt_waits_rsp", 32'(halted), 32'h0);
    p_rsp = 100;
    drive(); step();
    chk("halted_after_rsp", 32'(halted), 32'h1);
    drive(); step();
    halt = 0;
    drive(); step();
    chk("resume_req", 32'(imem_req), 32'h1);
    chk("resume_addr", imem_addr, resume_pc);
    p_gnt = 0;
    repeat (6) begin drive(); step(); end
    drive();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 0;
    p_gnt = 100;
    drive(); step();
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    p_gnt = 70; p_rsp = 60; p_rdy = 60; p_spur = 20;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(2);
      drive();
      redirect_valid = $urandom_range(0, 99) < 4;
      redirect_pc = $urandom;
      if ($urandom_range(0, 99) < 3) halt = !halt;
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter BOOT_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, instruction-buffer entries and maximum in-flight requests (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-005 SHALL have ports imem_req  output  1 and imem_addr  output  32, the instruction-memory request and its word address.
REQ-006 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-007 SHALL have ports imem_rvalid  input  1 and imem_rdata  input  32, the in-order read response.
REQ-008 SHALL have ports redirect_valid  input  1 and redirect_pc  input  32, branch/jump target from execute.
REQ-009 SHALL have port halt  input  1  stop issuing new fetches.
REQ-010 SHALL have ports instr_valid  output  1, instr  output  32 and instr_pc  output  32, the decode-side instruction and its PC.
REQ-011 SHALL have port instr_ready  input  1  decode accepts the instruction.
REQ-012 SHALL have port halted  output  1  high in HALTED state.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DRAIN and HALTED.
REQ-014 IDLE SHALL last exactly one cycle after reset deassertion, then go to RUN.
REQ-015 imem_req SHALL be 1 only when state=RUN, halt=0, redirect_valid=0 and outstanding+count < BUF_DEPTH.
REQ-016 imem_addr SHALL equal fetch_pc; fetch_pc[1:0] SHALL always be 0.
REQ-017 On imem_req&&imem_gnt, fetch_pc SHALL advance by 4 (32-bit wrap, 32'hFFFF_FFFC -> 0) and outstanding SHALL increment.
REQ-018 Each imem_rvalid SHALL decrement outstanding; in the same cycle, simultaneous grant and response SHALL leave outstanding unchanged.
REQ-019 A response with discard_cnt=0 SHALL be written to the FIFO with its PC tag (PC of the oldest outstanding request).
REQ-020 A response with discard_cnt>0 SHALL be dropped and discard_cnt decremented.
REQ-021 instr_valid SHALL be (count!=0) && !redirect_valid; instr/instr_pc SHALL show the FIFO head.
REQ-022 The FIFO SHALL pop on instr_valid&&instr_ready; simultaneous push and pop SHALL keep count unchanged.
REQ-023 Latency from grant to instr_valid SHALL be zero cycles beyond the response cycle plus one (registered write, visible the cycle after imem_rvalid).
REQ-024 On redirect_valid, the FIFO SHALL be flushed, fetch_pc loaded with {redirect_pc[31:2],2'b00}, and discard_cnt set to outstanding minus (imem_rvalid?1:0).
REQ-025 After a redirect, state SHALL be DRAIN if the new discard_cnt>0, else RUN.
REQ-026 DRAIN SHALL go to RUN in the cycle discard_cnt reaches 0; no requests SHALL issue in DRAIN.
REQ-027 Redirect SHALL take priority over halt, pop and response-push in the same cycle.
REQ-028 With halt=1 in RUN, state SHALL go to HALTED once outstanding=0; buffered instructions SHALL remain poppable.
REQ-029 HALTED SHALL return to RUN when halt=0; a redirect in HALTED SHALL load fetch_pc and stay HALTED while halt=1.
REQ-030 imem_rvalid with outstanding=0 SHALL be ignored.

Reset
REQ-031 While reset=0: state=IDLE, fetch_pc=BOOT_PC, count=outstanding=discard_cnt=0, imem_req=0, instr_valid=0, halted=0; instr/instr_pc SHALL read 0.
REQ-032 Reset mid-operation SHALL abandon all in-flight requests without discard accounting.

Structure
REQ-033 The state encoding, BOOT_PC default and PC increment constant (4) SHALL live in the shared processor package.
REQ-034 The PC-tagged instruction FIFO SHALL be a sub-module, fetch_buffer, parameterised by BUF_DEPTH.

Verification
REQ-035 Reset release, gnt=1, rvalid one cycle after grant, ready=1 -> addresses 0,4,8,... issued; instr_pc follows 0,4,8 with no bubbles after fill.
REQ-036 instr_ready=0 with BUF_DEPTH=2 -> at most 2 grants, then imem_req=0 until a pop.
REQ-037 Redirect to 0x100 with 2 outstanding -> both responses dropped in DRAIN; first delivered instr_pc=0x100.
REQ-038 Redirect with redirect_pc=0x203 -> imem_addr=0x200.
REQ-039 halt=1 with 1 outstanding -> halted=1 the cycle after its response; halt=0 -> RUN, fetch resumes at next PC.
REQ-040 fetch_pc=0xFFFF_FFFC granted -> next imem_addr=0x0000_0000.
